priority_decoder_2to4_buf: RTL and testbench
============================================

// Module: priority_decoder_2to4_buf
// PURPOSE
//  Receive side of the priority-encoder path: accepts encoded line indices
//  (CODE_W bits) over a valid/ready handshake, buffers them in a DEPTH-entry FIFO
//  and presents each one, in arrival order, as a one-hot OUT_W-bit vector on a
//  valid/ready output. Sits between the encoder stage and one-hot consumers
//  (line acknowledge/clear logic), absorbing back-pressure from those consumers.
// PARAMETERS
//  CODE_W  2          width of encoded index; OUT_W = 1<<CODE_W (4 by default)
//  DEPTH   4          FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1                 single clock, rising edge
//  rst_n       in   1                 asynchronous reset, active-low
//  in_code     in   CODE_W            encoded index, sampled when in_valid && in_ready
//  in_valid    in   1                 producer has a code
//  in_ready    out  1                 FIFO can accept
//  out_onehot  out  OUT_W             1<<head_code while out_valid, else all zero
//  out_valid   out  1                 head entry available
//  out_ready   in   1                 consumer takes head
//  level       out  $clog2(DEPTH+1)   entries stored (0..DEPTH)
// BEHAVIOUR
//  - Reset (rst_n low, async): rd/wr pointers = 0, level = 0, in_ready = 0 while
//    held low, out_valid = 0, out_onehot = 0. Storage contents are don't-care.
//  - First cycle after release: in_ready = 1.
//  - in_ready = (level != DEPTH); it does not depend on out_ready (no
//    combinational ready path in -> out).
//  - Push: in_valid && in_ready -> mem[wr_ptr] <= in_code, wr_ptr++ (wraps mod DEPTH).
//  - Pop: out_valid && out_ready -> rd_ptr++ (wraps mod DEPTH).
//  - level: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - out_valid = (level != 0). out_onehot = out_valid ? (1 << mem[rd_ptr]) : 0.
//    Exactly one bit is set whenever out_valid = 1.
//  - Latency: a code pushed at edge N is visible on out_* after edge N when
//    level was 0 (1 cycle, in-to-out).
//  - Output stability: once out_valid = 1, out_onehot stays constant until popped.
//  - Full (level = DEPTH): in_ready = 0. A pop in that cycle frees one slot, so
//    in_ready = 1 in the next cycle.
//  - Empty: out_valid = 0 and out_ready is ignored. A simultaneous push is legal.
//  - Push and pop in the same cycle at any 0 < level < DEPTH: level is held and
//    order is preserved.
//  - Pointer wrap: pointers are $clog2(DEPTH) bits and full/empty come from
//    level, so wrap needs no special case.
//  - in_valid while in_ready = 0: the code is not captured. The producer holds it.
//  - Reset mid-operation discards all stored codes immediately. Outputs go to
//    their reset values asynchronously.
// CONFIGURATION
//  DEC_BYPASS_EN (define): zero-latency bypass.
//  - When level == 0 and in_valid: out_valid = 1 and
//    out_onehot = 1 << in_code in the same cycle.
//  - If out_ready is also 1, the code is consumed directly. Nothing is written,
//    and level and pointers are unchanged.
//  - If out_ready = 0, the code is written normally (push).
//  - in_ready keeps its definition (level != DEPTH).
//  Undefined: no bypass. out_* depend on registered state only; 1-cycle latency.
// TESTING
//  1 Reset: rst_n=0 mid-traffic with level=3 -> out_valid=0, out_onehot=4'b0000,
//    level=0 immediately; after release in_ready=1.
//  2 Single code: push in_code=2'b10, out_ready=1 -> next cycle out_onehot=4'b0100,
//    out_valid=1, popped at that edge; level back to 0.
//    With DEC_BYPASS_EN: 4'b0100 in the push cycle, level stays 0.
//  3 Fill/backpressure: out_ready=0, push 3,0,1,2 -> level=4, in_ready=0;
//    fifth code 3 is held off. Then out_ready=1 -> outputs 4'b1000, 0001, 0010,
//    0100, 1000 in order.
//  4 Simultaneous push/pop at level=2 for 8 cycles with codes 0..3 repeating ->
//    level stays 2, order preserved, pointers wrap twice.
//  5 Full+pop: level=4, out_ready=1, in_valid=1 -> no push that cycle;
//    in_ready=1 next cycle; push accepted and level returns to 4.
//  6 Random: 10k cycles of random in_valid/out_ready checked against a scoreboard
//    queue. out_onehot is one-hot whenever out_valid=1 and is stable while
//    stalled.

Source files
------------

// File: rtl/priority_decoder_2to4_buf.sv
// Buffered 2-to-4 decoder: a DEPTH-entry FIFO of encoded indices presented as one-hot on a valid/ready output.
// Optional zero-latency bypass when empty is enabled by defining DEC_BYPASS_EN.
module priority_decoder_2to4_buf #(
    parameter  int CODE_W = 2,
    parameter  int DEPTH  = 4,
    localparam int OUT_W  = 1 << CODE_W,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_onehot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic              bypass;
    logic              fifo_valid;
    logic              push;
    logic              pop;
    logic [CODE_W-1:0] head_code;

    // rst_n gates in_ready and the bypass so every output sits at its reset value while reset is held.
    always_comb begin
        bypass = 1'b0;
`ifdef DEC_BYPASS_EN
        bypass = rst_n && in_valid && (level_q == '0);
`endif
        in_ready   = rst_n && (level_q != LVL_W'(DEPTH));
        fifo_valid = (level_q != '0);
        out_valid  = fifo_valid || bypass;
        head_code  = bypass ? in_code : mem_q[rd_ptr_q];
        out_onehot = out_valid ? (OUT_W'(1) << head_code) : '0;
        pop        = fifo_valid && out_ready;
        push       = in_valid && in_ready && !(bypass && out_ready);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_code;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; level decides which entries are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign level = level_q;

endmodule

// File: tb/tb_priority_decoder_2to4_buf.sv
// Directed and scoreboard-checked bench for priority_decoder_2to4_buf (default DEPTH=4, CODE_W=2).
module tb_priority_decoder_2to4_buf;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;

    int tests_run;
    int tests_failed;

    priority_decoder_2to4_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_code   = 2'd0;
        #2;
        tests_run++;
        if (level !== 3'd0 || out_valid !== 1'b0 || out_onehot !== 4'b0000 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: level=%0d valid=%b onehot=%b in_ready=%b, want 0/0/0000/0",
                     level, out_valid, out_onehot, in_ready);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
        end
        in_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            in_code = 2'(c);
            tick();
        end
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (level !== 3'd3 || out_onehot !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL reset_pre_level: level=%0d onehot=%b, want 3/0010", level, out_onehot);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (level !== 3'd0 || out_valid !== 1'b0 || out_onehot !== 4'b0000 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_midtraffic: level=%0d valid=%b onehot=%b in_ready=%b, want 0/0/0000/0",
                     level, out_valid, out_onehot, in_ready);
        end
        tick();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rerelease: in_ready=%b valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        tick();
        in_code   = 2'b10;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        tests_run++;
`ifdef DEC_BYPASS_EN
        if (out_valid !== 1'b1 || out_onehot !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL single_bypass: valid=%b onehot=%b, want 1/0100", out_valid, out_onehot);
        end
`else
        if (out_valid !== 1'b0 || out_onehot !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL single_push_cycle: valid=%b onehot=%b, want 0/0000", out_valid, out_onehot);
        end
`endif
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
`ifdef DEC_BYPASS_EN
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_after_bypass: valid=%b level=%0d, want 0/0", out_valid, level);
        end
`else
        if (out_valid !== 1'b1 || out_onehot !== 4'b0100 || level !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_out: valid=%b onehot=%b level=%0d, want 1/0100/1",
                     out_valid, out_onehot, level);
        end
`endif
        tick();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_popped: valid=%b level=%0d, want 0/0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd3; tick();
        in_code   = 2'd0; tick();
        in_code   = 2'd1; tick();
        in_code   = 2'd2; tick();
        in_code   = 2'd3;
        #1;
        tests_run++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fill_full: level=%0d in_ready=%b, want 4/0", level, in_ready);
        end
        tick();
        tests_run++;
        if (level !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL fill_holdoff: level=%0d, want 4", level);
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_onehot !== exp_seq[i]) begin
                tests_failed++;
                $display("[TB] FAIL fill_drain_%0d: valid=%b onehot=%b, want 1/%b", i, out_valid, out_onehot, exp_seq[i]);
            end
            if (i < 2) begin
                tests_run++;
                if (in_ready !== (i == 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL fill_ready_%0d: in_ready=%b, want %b", i, in_ready, (i == 1));
                end
            end
            tick();
            if (i == 1) in_valid = 1'b0;
            #1;
        end
        tests_run++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fill_empty: level=%0d valid=%b, want 0/0", level, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd0; tick();
        in_code   = 2'd1; tick();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_code = 2'((k + 2) % 4);
            #1;
            tests_run++;
            if (level !== 3'd2 || out_onehot !== (4'b0001 << (k % 4))) begin
                tests_failed++;
                $display("[TB] FAIL b2b_%0d: level=%0d onehot=%b, want 2/%b", k, level, out_onehot, 4'b0001 << (k % 4));
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_onehot !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL b2b_tail0: onehot=%b, want 0001", out_onehot);
        end
        tick();
        tests_run++;
        if (out_onehot !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL b2b_tail1: onehot=%b, want 0010", out_onehot);
        end
        tick();
        tests_run++;
        if (level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_empty: level=%0d, want 0", level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_code = 2'(c);
            tick();
        end
        in_code   = 2'd2;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || level !== 3'd4 || out_onehot !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL fullpop_full: in_ready=%b level=%0d onehot=%b, want 0/4/0001", in_ready, level, out_onehot);
        end
        tick();
        out_ready = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || level !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL fullpop_freed: in_ready=%b level=%0d, want 1/3", in_ready, level);
        end
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (level !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL fullpop_refill: level=%0d, want 4", level);
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_onehot !== exp_seq[i]) begin
                tests_failed++;
                $display("[TB] FAIL fullpop_drain_%0d: onehot=%b, want %b", i, out_onehot, exp_seq[i]);
            end
            tick();
        end
        tests_run++;
        if (level !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL fullpop_empty: level=%0d, want 0", level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] q[$];
        logic       hold;
        logic       prev_stall;
        logic [3:0] prev_onehot;
        logic       exp_valid;
        logic [1:0] exp_code;
        logic       exp_ready;
        logic [3:0] exp_onehot;
        logic [2:0] exp_level;
        logic       acc;
        logic       popm;
        logic       direct;
        hold        = 1'b0;
        prev_stall  = 1'b0;
        prev_onehot = 4'b0000;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        tick();
        for (int i = 0; i < 10000; i++) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_code  = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 99) < ((i % 2000) < 1000 ? 30 : 80));
            #1;
            exp_valid = (q.size() != 0);
            exp_code  = (q.size() != 0) ? q[0] : 2'd0;
            direct    = 1'b0;
`ifdef DEC_BYPASS_EN
            if (q.size() == 0 && in_valid) begin
                exp_valid = 1'b1;
                exp_code  = in_code;
                direct    = out_ready;
            end
`endif
            exp_ready  = (q.size() != 4);
            exp_onehot = exp_valid ? (4'b0001 << exp_code) : 4'b0000;
            exp_level  = 3'(q.size());
            tests_run++;
            if (out_valid !== exp_valid || out_onehot !== exp_onehot || in_ready !== exp_ready || level !== exp_level) begin
                tests_failed++;
                $display("[TB] FAIL rand_%0d: valid=%b onehot=%b in_ready=%b level=%0d, want %b/%b/%b/%0d",
                         i, out_valid, out_onehot, in_ready, level, exp_valid, exp_onehot, exp_ready, exp_level);
            end
            if (out_valid === 1'b1) begin
                tests_run++;
                if (!$onehot(out_onehot)) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_onehot_%0d: onehot=%b, want exactly one bit", i, out_onehot);
                end
            end
            if (prev_stall) begin
                tests_run++;
                if (out_onehot !== prev_onehot) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_stable_%0d: onehot=%b, want %b", i, out_onehot, prev_onehot);
                end
            end
            acc  = in_valid && exp_ready;
            popm = (q.size() != 0) && out_ready;
            if (!direct) begin
                if (popm) void'(q.pop_front());
                if (acc) q.push_back(in_code);
            end
            prev_stall  = exp_valid && !out_ready;
            prev_onehot = exp_onehot;
            hold        = in_valid && !acc;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_full_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
